// File: rtl/player2_ctrl_if.sv
// Map-lookup handshake between the player-2 controller (master) and the tile map (slave).
// The map answers query_free exactly one cycle after query_valid.
interface player2_ctrl_if;
  logic       query_valid;
  logic [4:0] query_tile_x;
  logic [3:0] query_tile_y;
  logic       query_free;

  modport master (output query_valid, query_tile_x, query_tile_y, input query_free);
  modport slave  (input query_valid, query_tile_x, query_tile_y, output query_free);
endinterface

// File: rtl/player2_ctrl.sv
// Player-2 movement/animation controller: turns frame-rate key samples into 32x32 tile moves,
// checks the target tile against the map and drives sprite position and frame number.
module player2_ctrl #(
  parameter logic [9:0] START_X  = 10'd32,
  parameter logic [9:0] START_Y  = 10'd32,
  parameter int         STEP     = 2,
  parameter int         ANIM_DIV = 8,
  parameter int         MAP_W    = 20,
  parameter int         MAP_H    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  key_up,
  input  logic                  key_down,
  input  logic                  key_left,
  input  logic                  key_right,
  player2_ctrl_if.master        qif,
  output logic [9:0]            player2_centerX,
  output logic [9:0]            player2_centerY,
  output logic [2:0]            sprite_num,
  output logic                  moving
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_WAIT, S_MOVING} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t          state;
  dir_t            dir;
  logic [CW-1:0]   anim_cnt;
  logic            phase;

  function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic dec);
    return dec ? (pos - 10'(STEP)) : (pos + 10'(STEP));
  endfunction

  function automatic logic [2:0] dir_base(input dir_t d);
    case (d)
      DIR_LEFT:  return 3'd3;
      DIR_RIGHT: return 3'd5;
      default:   return 3'd1;
    endcase
  endfunction

  // Target-tile selection: key priority up > down > left > right, with map-edge check.
  logic [4:0] cur_tx, tgt_x;
  logic [3:0] cur_ty, tgt_y;
  logic       req, tgt_ok;
  dir_t       req_dir;

  assign cur_tx = player2_centerX[9:5];
  assign cur_ty = player2_centerY[8:5];

  always_comb begin
    req     = 1'b0;
    req_dir = DIR_UP;
    tgt_ok  = 1'b0;
    tgt_x   = cur_tx;
    tgt_y   = cur_ty;
    if (key_up) begin
      req = 1'b1; req_dir = DIR_UP;
      tgt_ok = (cur_ty != 4'd0);
      tgt_y  = cur_ty - 4'd1;
    end else if (key_down) begin
      req = 1'b1; req_dir = DIR_DOWN;
      tgt_ok = (cur_ty < 4'(MAP_H - 1));
      tgt_y  = cur_ty + 4'd1;
    end else if (key_left) begin
      req = 1'b1; req_dir = DIR_LEFT;
      tgt_ok = (cur_tx != 5'd0);
      tgt_x  = cur_tx - 5'd1;
    end else if (key_right) begin
      req = 1'b1; req_dir = DIR_RIGHT;
      tgt_ok = (cur_tx < 5'(MAP_W - 1));
      tgt_x  = cur_tx + 5'd1;
    end
  end

  // Next position on the latched axis; arrival is the next tile-aligned coordinate.
  logic       vertical, arrive, phase_nxt;
  logic [9:0] nxt_pos;

  assign vertical  = (dir == DIR_UP) || (dir == DIR_DOWN);
  assign nxt_pos   = step_pos(vertical ? player2_centerY : player2_centerX,
                              (dir == DIR_UP) || (dir == DIR_LEFT));
  assign arrive    = (nxt_pos[4:0] == 5'd0);
  assign phase_nxt = (anim_cnt == CW'(ANIM_DIV - 1)) ? ~phase : phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      dir              <= DIR_UP;
      player2_centerX  <= START_X;
      player2_centerY  <= START_Y;
      sprite_num       <= 3'd0;
      moving           <= 1'b0;
      anim_cnt         <= '0;
      phase            <= 1'b0;
      qif.query_valid  <= 1'b0;
      qif.query_tile_x <= 5'd0;
      qif.query_tile_y <= 4'd0;
    end else begin
      qif.query_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_tick && req) begin
            if (tgt_ok) begin
              dir              <= req_dir;
              qif.query_valid  <= 1'b1;
              qif.query_tile_x <= tgt_x;
              qif.query_tile_y <= tgt_y;
              state            <= S_QUERY;
            end else begin
              sprite_num <= 3'd0;
            end
          end
        end
        S_QUERY: state <= S_WAIT;
        S_WAIT: begin
          if (qif.query_free) begin
            state      <= S_MOVING;
            moving     <= 1'b1;
            anim_cnt   <= '0;
            phase      <= 1'b0;
            sprite_num <= dir_base(dir);
          end else begin
            state      <= S_IDLE;
            sprite_num <= 3'd0;
          end
        end
        S_MOVING: begin
          if (frame_tick) begin
            if (vertical) player2_centerY <= nxt_pos;
            else          player2_centerX <= nxt_pos;
            anim_cnt <= (anim_cnt == CW'(ANIM_DIV - 1)) ? '0 : anim_cnt + 1'b1;
            phase    <= phase_nxt;
            if (arrive) begin
              state      <= S_IDLE;
              moving     <= 1'b0;
              sprite_num <= 3'd0;
            end else begin
              sprite_num <= dir_base(dir) + {2'b00, phase_nxt};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
